btn_pulse_gen: RTL and testbench

Debounced push-button front end that turns a raw, bouncing board button into a clean level and single-cycle event pulses. It produces the trigger for the team's sticky-latch state machines: `press_pulse` drives a latch's set input directly. It sits between the board pin and the control FSMs in the 100 MHz domain.

---
 rtl/btn_pulse_gen.sv | 129 ++++++++++++
 tb/tb_btn_pulse_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// Debounced push-button front end: two-flop synchronizer, debounce FSM, registered press/release pulses.
// Define BTN_RELEASE_PULSE_EN to build the release_pulse flop; otherwise release_pulse is tied to 0.
module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             btn_level_q, btn_level_d;
  logic             press_pulse_q, press_pulse_d;
`ifdef BTN_RELEASE_PULSE_EN
  logic             release_pulse_q, release_pulse_d;
`endif

  // The shared counter is cleared on every exit from a debounce state, so it never wraps.
  always_comb begin
    sync1_d       = btn_in;
    sync2_d       = sync1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    btn_level_d   = btn_level_q;
    press_pulse_d = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
    release_pulse_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = PRESSED;
          cnt_d         = '0;
          btn_level_d   = 1'b1;
          press_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          btn_level_d = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
          release_pulse_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      btn_level_q   <= 1'b0;
      press_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      btn_level_q   <= btn_level_d;
      press_pulse_q <= press_pulse_d;
    end
  end

`ifdef BTN_RELEASE_PULSE_EN
  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      release_pulse_q <= 1'b0;
    end else begin
      release_pulse_q <= release_pulse_d;
    end
  end

  assign release_pulse = release_pulse_q;
`else
  assign release_pulse = 1'b0;
`endif

  assign btn_level   = btn_level_q;
  assign press_pulse = press_pulse_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen (D=4): a run-length reference model feeds a scoreboard,
// and each scenario task adds directed cycle-exact checks.
module tb_btn_pulse_gen;

  localparam int D = 4;

`ifdef BTN_RELEASE_PULSE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic clock_100Mhz = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  logic       m_s1 = 1'b0;
  logic       m_s2 = 1'b0;
  logic       m_level = 1'b0;
  int         m_run = 0;
  logic [2:0] sb[$];
  int         n_cmp = 0;
  int         n_fail = 0;

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  // A level change is accepted once the synchronized input has disagreed with it for D+1 edges.
  task automatic tick();
    logic p, r;
    @(posedge clock_100Mhz);
    p = 1'b0;
    r = 1'b0;
    if (!reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0;
    end else begin
      if (m_s2 !== m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = m_s2;
          p = m_s2;
          r = ~m_s2 & REL_EN;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
    sb.push_back({m_level, p, r});
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    reset = 1'b0;
    btn_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = sb.pop_front(); n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== exp) begin
        n_fail++; $display("[TB] FAIL reset_sb cycle %0d: got %b want %b", i, {btn_level, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
        n_fail++; $display("[TB] FAIL reset_outputs cycle %0d: got %b want 000", i, {btn_level, press_pulse, release_pulse});
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp = sb.pop_front(); n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== exp) begin
        n_fail++; $display("[TB] FAIL post_reset_sb cycle %0d: got %b want %b", i, {btn_level, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if (press_pulse !== (i == 7) || btn_level !== (i >= 7)) begin
        n_fail++; $display("[TB] FAIL post_reset_press cycle %0d: got press=%b level=%b want press=%b level=%b", i, press_pulse, btn_level, i == 7, i >= 7);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [2:0] exp;
    logic [6:0] pat = 7'b0000100;
    for (int i = 1; i <= 12; i++) begin
      btn_in = (i <= 7) ? pat[i-1] : 1'b0;
      tick();
      exp = sb.pop_front(); n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== exp) begin
        n_fail++; $display("[TB] FAIL release_sb cycle %0d: got %b want %b", i, {btn_level, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if (btn_level !== (i < 10) || release_pulse !== (REL_EN && i == 10) || press_pulse !== 1'b0) begin
        n_fail++; $display("[TB] FAIL release_timing cycle %0d: got level=%b rel=%b press=%b want level=%b rel=%b press=0",
                           i, btn_level, release_pulse, press_pulse, i < 10, REL_EN && i == 10);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp;
    btn_in = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp = sb.pop_front(); n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== exp) begin
        n_fail++; $display("[TB] FAIL clean_press_sb cycle %0d: got %b want %b", i, {btn_level, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if (press_pulse !== (i == 7) || btn_level !== (i >= 7)) begin
        n_fail++; $display("[TB] FAIL clean_press_timing cycle %0d: got press=%b level=%b want press=%b level=%b", i, press_pulse, btn_level, i == 7, i >= 7);
      end
    end
  endtask

  task automatic test_idle_hold();
    logic [2:0] exp;
    btn_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = sb.pop_front(); n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== exp) begin
        n_fail++; $display("[TB] FAIL idle_hold_sb cycle %0d: got %b want %b", i, {btn_level, press_pulse, release_pulse}, exp);
      end
    end
    n_cmp++;
    if (btn_level !== 1'b0) begin
      n_fail++; $display("[TB] FAIL idle_hold_level: got %b want 0", btn_level);
    end
  endtask

  task automatic test_bounce();
    logic [2:0] exp;
    logic [7:0] pat = 8'b1111_1011;
    int pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      btn_in = (i <= 8) ? pat[i-1] : 1'b1;
      tick();
      if (press_pulse === 1'b1) pulses++;
      exp = sb.pop_front(); n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== exp) begin
        n_fail++; $display("[TB] FAIL bounce_sb cycle %0d: got %b want %b", i, {btn_level, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if (press_pulse !== (i == 10) || btn_level !== (i >= 10)) begin
        n_fail++; $display("[TB] FAIL bounce_timing cycle %0d: got press=%b level=%b want press=%b level=%b", i, press_pulse, btn_level, i == 10, i >= 10);
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++; $display("[TB] FAIL bounce_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    btn_in = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      reset = (i <= 5) ? 1'b1 : 1'b0;
      tick();
      exp = sb.pop_front(); n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== exp) begin
        n_fail++; $display("[TB] FAIL reset_mid_sb cycle %0d: got %b want %b", i, {btn_level, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
        n_fail++; $display("[TB] FAIL reset_mid_quiet cycle %0d: got %b want 000", i, {btn_level, press_pulse, release_pulse});
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp = sb.pop_front(); n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== exp) begin
        n_fail++; $display("[TB] FAIL reset_mid_resume_sb cycle %0d: got %b want %b", i, {btn_level, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if (press_pulse !== (i == 7) || btn_level !== (i >= 7)) begin
        n_fail++; $display("[TB] FAIL reset_mid_resume cycle %0d: got press=%b level=%b want press=%b level=%b", i, press_pulse, btn_level, i == 7, i >= 7);
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] exp;
    for (int i = 1; i <= 12; i++) begin
      btn_in = (i <= 3) ? 1'b1 : 1'b0;
      tick();
      exp = sb.pop_front(); n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== exp) begin
        n_fail++; $display("[TB] FAIL glitch_sb cycle %0d: got %b want %b", i, {btn_level, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
        n_fail++; $display("[TB] FAIL glitch_quiet cycle %0d: got %b want 000", i, {btn_level, press_pulse, release_pulse});
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    btn_in = 1'b0;
    test_reset();
    test_release_bounce();
    test_clean_press();
    test_idle_hold();
    test_bounce();
    test_idle_hold();
    test_reset_mid();
    test_idle_hold();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
